// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_arb_pkg : shared constants and entry types for the FIFO drain arbiter |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
package fifo_arb_pkg;

  localparam int c_SKID_DEPTH = 2;
  localparam int c_ID_WIDTH   = 2;
  localparam int c_DATA_WIDTH = 64;

  typedef logic [c_ID_WIDTH-1:0] id_t;

  typedef struct packed {
    id_t                   id;
    logic [c_DATA_WIDTH-1:0] data;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/fifo_drain_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_pick : combinational round-robin selector, search starts at i_last + 1   |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  localparam int c_PW = (N > 1) ? $clog2(N) : 1;

  // Walk from the farthest candidate to the nearest so the nearest request wins.
  always_comb begin : p_pick
    int w_pos;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = N; k >= 1; k--) begin
      w_pos = int'(i_last) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if ((w_pos < N) && i_req[c_PW'(w_pos)]) begin
        o_grant                = '0;
        o_grant[c_PW'(w_pos)]  = 1'b1;
        o_idx                  = IDX_W'(w_pos);
        o_valid                = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_drain_arbiter : round-robin pop scheduler over NUM_FIFO FIFOs with a  |
// | 2-entry skid buffer. Optional burst grants: ARB_BURST_EN. Revision 1.0     |
// +--------------------------------------------------------------------------+
module fifo_drain_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_FIFO   = 4,
  parameter int DATA_WIDTH = c_DATA_WIDTH,
  parameter int ID_WIDTH   = c_ID_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_FIFO-1:0]            fifo_empty,
  output logic [NUM_FIFO-1:0]            fifo_pop,
  input  logic [NUM_FIFO*DATA_WIDTH-1:0] fifo_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [ID_WIDTH-1:0]            out_id
);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [DATA_WIDTH-1:0] data;
  } skid_entry_t;

  if (NUM_FIFO < 2 || NUM_FIFO > 16 || ID_WIDTH < $clog2(NUM_FIFO) || MAX_BURST < 1)
  begin : g_param_check
    $error("fifo_drain_arbiter: illegal parameter combination");
  end

  skid_entry_t           r_buf [c_SKID_DEPTH];
  logic [1:0]            r_occ;
  logic                  r_inflight;
  logic [ID_WIDTH-1:0]   r_inflight_id;
  logic [ID_WIDTH-1:0]   r_last_grant;

  logic [DATA_WIDTH-1:0] w_word [NUM_FIFO];
  logic [NUM_FIFO-1:0]   w_req;
  logic [NUM_FIFO-1:0]   w_rr_grant;
  logic [ID_WIDTH-1:0]   w_rr_idx;
  logic                  w_rr_valid;
  logic [NUM_FIFO-1:0]   w_grant;
  logic [ID_WIDTH-1:0]   w_idx;
  logic                  w_valid;
  logic                  w_handshake;
  logic                  w_credit;
  logic                  w_fire;
  skid_entry_t           w_cap;

  for (genvar gi = 0; gi < NUM_FIFO; gi++) begin : g_word
    assign w_word[gi] = fifo_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  assign w_req = ~fifo_empty;

  rr_pick #(
    .N     (NUM_FIFO),
    .IDX_W (ID_WIDTH)
  ) u_rr_pick (
    .i_req   (w_req),
    .i_last  (r_last_grant),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_valid (w_rr_valid)
  );

`ifdef ARB_BURST_EN
  localparam int c_BCNT_W = $clog2(MAX_BURST + 1);
  logic [c_BCNT_W-1:0] r_burst_cnt;
  logic                w_hold;

  assign w_hold  = (r_burst_cnt != '0) && (r_burst_cnt < c_BCNT_W'(MAX_BURST)) &&
                   !fifo_empty[r_last_grant];
  assign w_valid = w_hold | w_rr_valid;
  assign w_idx   = w_hold ? r_last_grant : w_rr_idx;
  assign w_grant = w_hold ? (NUM_FIFO'(1) << r_last_grant) : w_rr_grant;

  // A starved cycle keeps the burst alive; only an empty burst FIFO ends it early.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (w_fire) begin
      r_burst_cnt <= w_hold ? r_burst_cnt + c_BCNT_W'(1) : c_BCNT_W'(1);
    end else if ((r_burst_cnt != '0) && fifo_empty[r_last_grant]) begin
      r_burst_cnt <= '0;
    end
  end
`else
  assign w_valid = w_rr_valid;
  assign w_idx   = w_rr_idx;
  assign w_grant = w_rr_grant;
`endif

  assign out_valid   = (r_occ != 2'd0);
  assign out_data    = r_buf[0].data;
  assign out_id      = r_buf[0].id;
  assign w_handshake = out_valid & out_ready;
  // Words already owed to the buffer (held + in flight) minus the one leaving now.
  assign w_credit    = (({1'b0, r_occ} + {2'b00, r_inflight}) - {2'b00, w_handshake})
                       < 3'(c_SKID_DEPTH);
  assign w_fire      = w_valid & w_credit & ~reset;
  assign fifo_pop    = w_fire ? w_grant : '0;

  assign w_cap.id    = r_inflight_id;
  assign w_cap.data  = w_word[r_inflight_id];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_occ         <= 2'd0;
      r_buf[0]      <= '0;
      r_buf[1]      <= '0;
      r_inflight    <= 1'b0;
      r_inflight_id <= '0;
      r_last_grant  <= ID_WIDTH'(NUM_FIFO - 1);
    end else begin
      r_inflight <= w_fire;
      if (w_fire) begin
        r_inflight_id <= w_idx;
        r_last_grant  <= w_idx;
      end
      case ({r_inflight, w_handshake})
        2'b01: begin
          r_buf[0] <= r_buf[1];
          r_occ    <= r_occ - 2'd1;
        end
        2'b10: begin
          if (r_occ == 2'd0) r_buf[0] <= w_cap;
          else               r_buf[1] <= w_cap;
          r_occ <= r_occ + 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd1) begin
            r_buf[0] <= w_cap;
          end else begin
            r_buf[0] <= r_buf[1];
            r_buf[1] <= w_cap;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_drain_arbiter : queue-based reference model and directed scenarios |
// | Revision 1.0                                                               |
// +--------------------------------------------------------------------------+
module tb_fifo_drain_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;
`ifdef ARB_BURST_EN
  localparam int MB = 2;
`else
  localparam int MB = 4;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    fifo_empty;
  logic [N-1:0]    fifo_pop;
  logic [N*DW-1:0] fifo_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_id;

  fifo_drain_arbiter #(
    .NUM_FIFO(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_data(fifo_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
  } ent_t;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  logic [DW-1:0] fq [N][$];
  logic [DW-1:0] dout [N];
  ent_t          mbuf [$];
  bit            minfl;
  ent_t          minfl_e;
  int            mlast;
  int            mburst;
  int            push_pct;
  bit            rand_ready;

  logic [N-1:0]  obs_pop;
  logic          obs_valid;
  logic          obs_ready;
  logic [DW-1:0] obs_data;
  logic [IW-1:0] obs_id;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_fifo_if();
    for (int i = 0; i < N; i++) begin
      fifo_data[i*DW +: DW] = dout[i];
      fifo_empty[i]         = (fq[i].size() == 0);
    end
  endtask

  task automatic push(input int f, input logic [DW-1:0] d);
    fq[f].push_back(d);
    drive_fifo_if();
  endtask

  // Reference: which FIFO should be popped this cycle, from queue contents and credit.
  task automatic model_pick(output logic [N-1:0] e_pop, output int win, output bit held);
    int hs;
    e_pop = '0;
    win   = -1;
    held  = 1'b0;
    if (reset) return;
    hs = ((mbuf.size() > 0) && out_ready) ? 1 : 0;
    if (mbuf.size() + int'(minfl) - hs >= 2) return;
`ifdef ARB_BURST_EN
    if (mburst > 0 && mburst < MB && fq[mlast].size() > 0) begin
      win  = mlast;
      held = 1'b1;
    end
`endif
    if (win < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (fq[(mlast + k) % N].size() > 0) begin
          win = (mlast + k) % N;
          break;
        end
      end
    end
    if (win >= 0) e_pop[win] = 1'b1;
  endtask

  task automatic cycle_step();
    logic [N-1:0] e_pop;
    int           win;
    bit           held;
    bit           hs;
    bit           last_empty;
    ent_t         nxt;
    @(negedge clk);
    model_pick(e_pop, win, held);
    hs         = (mbuf.size() > 0) && out_ready;
    last_empty = (fq[mlast].size() == 0);
    obs_pop    = fifo_pop;
    obs_valid  = out_valid;
    obs_ready  = out_ready;
    obs_data   = out_data;
    obs_id     = out_id;
    check("pop", 64'(fifo_pop), 64'(e_pop));
    check("valid", 64'(out_valid), 64'(mbuf.size() > 0));
    if (mbuf.size() > 0) begin
      check("data", out_data, mbuf[0].data);
      check("id", 64'(out_id), 64'(mbuf[0].id));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        fq[i].delete();
        dout[i] = '0;
      end
      mbuf.delete();
      minfl  = 1'b0;
      mlast  = N - 1;
      mburst = 0;
    end else begin
      nxt = '0;
      if (win >= 0) begin
        nxt.id   = IW'(win);
        nxt.data = (fq[win].size() > 0) ? fq[win][0] : '0;
      end
      for (int i = 0; i < N; i++)
        if (obs_pop[i] && fq[i].size() > 0) dout[i] = fq[i].pop_front();
      if (hs) void'(mbuf.pop_front());
      if (minfl) mbuf.push_back(minfl_e);
      minfl   = (win >= 0);
      minfl_e = nxt;
      if (win >= 0) begin
        mburst = held ? mburst + 1 : 1;
        mlast  = win;
      end else if (last_empty) begin
        mburst = 0;
      end
      for (int i = 0; i < N; i++)
        if (push_pct > 0 && $urandom_range(99) < push_pct && fq[i].size() < 6)
          fq[i].push_back({$urandom(), $urandom()});
      if (rand_ready) out_ready = ($urandom_range(3) != 0);
    end
    drive_fifo_if();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle_step();
    cycle_step();
    reset = 1'b0;
  endtask

  initial begin : main
    int           exp_b [12];
    logic [DW-1:0] hs_words [$];
    int           npop;
    reset      = 1'b1;
    out_ready  = 1'b1;
    push_pct   = 0;
    rand_ready = 1'b0;
    minfl      = 1'b0;
    minfl_e    = '0;
    mlast      = N - 1;
    mburst     = 0;
    for (int i = 0; i < N; i++) dout[i] = '0;
    drive_fifo_if();
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    check("R_valid", 64'(obs_valid), 64'(0));
    check("R_data", obs_data, 64'h0);
    check("R_id", 64'(obs_id), 64'(0));
    check("R_pop", 64'(obs_pop), 64'(0));

    // Single word from FIFO 2: pop in cycle 0, output in cycle 2
    push(2, 64'hA0);
    cycle_step();
    check("A_pop_c0", 64'(obs_pop), 64'(4'b0100));
    cycle_step();
    check("A_valid_c1", 64'(obs_valid), 64'(0));
    cycle_step();
    check("A_valid_c2", 64'(obs_valid), 64'(1));
    check("A_data_c2", obs_data, 64'hA0);
    check("A_id_c2", 64'(obs_id), 64'(2));

    // Four FIFOs with 3 words each, consumer always ready
    do_reset();
`ifdef ARB_BURST_EN
    exp_b = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 1, 2, 3};
`else
    exp_b = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int f = 0; f < N; f++)
      for (int k = 0; k < 3; k++) push(f, 64'(16'h100 * f + k));
    for (int c = 0; c < 16; c++) begin
      cycle_step();
      if (c < 12) check("B_pop_idx", 64'(oh2idx(obs_pop)), 64'(exp_b[c]));
      if (c >= 2 && c < 14) begin
        check("B_valid", 64'(obs_valid), 64'(1));
        check("B_id", 64'(obs_id), 64'(exp_b[c-2]));
      end
    end

    // Back-pressure: 5 words in FIFO 1, ready low during cycles 1..6
    do_reset();
    for (int k = 0; k < 5; k++) push(1, 64'(8'hC0 + k));
    npop = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 1 && c <= 6);
      cycle_step();
      if (obs_pop != '0) npop++;
      if (c == 6) check("C_pops_held", 64'(npop), 64'(2));
      if (c >= 2 && c <= 6) begin
        check("C_valid_held", 64'(obs_valid), 64'(1));
        check("C_data_stable", obs_data, 64'hC0);
      end
      if (obs_valid && obs_ready) hs_words.push_back(obs_data);
    end
    check("C_pops_total", 64'(npop), 64'(5));
    check("C_delivered", 64'(hs_words.size()), 64'(5));
    for (int k = 0; k < 5 && k < hs_words.size(); k++)
      check("C_order", hs_words[k], 64'(8'hC0 + k));

    // Only FIFO 3 eligible: pointer wraps and re-grants 3 with no idle cycle
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) push(3, 64'(8'hD0 + k));
    for (int c = 0; c < 4; c++) begin
      cycle_step();
      check("D_pop", 64'(obs_pop), (c < 3) ? 64'(4'b1000) : 64'(0));
    end

    // Reset while one word is buffered and one is in flight
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(0, 64'(8'hE0 + k));
    cycle_step();
    check("E_pop_c0", 64'(obs_pop), 64'(4'b0001));
    cycle_step();
    check("E_pop_c1", 64'(obs_pop), 64'(4'b0001));
    reset = 1'b1;
    cycle_step();
    reset = 1'b0;
    out_ready = 1'b1;
    cycle_step();
    check("E_valid", 64'(obs_valid), 64'(0));
    check("E_pop", 64'(obs_pop), 64'(0));
    check("E_data", obs_data, 64'h0);
    for (int c = 0; c < 4; c++) begin
      cycle_step();
      check("E_no_ghost", 64'(obs_valid), 64'(0));
    end

    // Randomized traffic, back-pressure and occasional resets
    do_reset();
    rand_ready = 1'b1;
    for (int blk = 0; blk < 8; blk++) begin
      push_pct = $urandom_range(10, 90);
      for (int c = 0; c < 500; c++) begin
        reset = ($urandom_range(299) == 0);
        cycle_step();
      end
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_drain_arbiter.md
# fifo_drain_arbiter

Round-robin read-side scheduler that shares one downstream consumer between NUM_FIFO instances of the team's single-clock `fifo`. It watches each FIFO's `empty` flag and issues at most one one-hot `pop` per cycle. It absorbs the FIFO's one-cycle registered read latency and presents the winning word with its source index on a valid/ready output stream. It sits between the per-PE output FIFOs and the shared write-back/memory-interface path.

## Interface
- NUM_FIFO, 4: number of FIFOs arbitrated (2..16).
- DATA_WIDTH, 64: word width; must match the FIFOs' DATA_WIDTH.
- ID_WIDTH, 2: width of source index; must be ≥ ceil(log2(NUM_FIFO)).
- MAX_BURST, 4: maximum consecutive pops on one FIFO (used only with ARB_BURST_EN).
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- fifo_empty  in  NUM_FIFO  per-FIFO `empty` flag; bit i belongs to FIFO i.
- fifo_pop  out  NUM_FIFO  one-hot-or-zero pop strobe; bit i drives FIFO i `pop`.
- fifo_data  in  NUM_FIFO*DATA_WIDTH  concatenated FIFO `data_out`; FIFO i at [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  DATA_WIDTH  output word.
- out_id  out  ID_WIDTH  index of the FIFO that supplied out_data.

## Operation
- Eligible FIFO: fifo_empty[i] == 0.
- Round-robin pointer `last_grant` starts at NUM_FIFO-1 after reset. Search order is last_grant+1, last_grant+2, … modulo NUM_FIFO. The first eligible FIFO wins.
- Pop is issued only if credit is available: occ + inflight − (out_valid && out_ready) < 2.
  - occ is the number of words held in the 2-entry output skid buffer (0..2).
  - inflight is the pop issued in the previous cycle (0/1).
- Winner i with credit: fifo_pop[i] = 1 this cycle; last_grant ← i; inflight ← 1 with captured id i.
- The cycle after a pop, fifo_data[id] is written into the skid buffer tail with id.
- Skid buffer is FIFO ordered; the head drives out_data/out_id/out_valid.
- A simultaneous capture and output handshake keeps occ unchanged.
- Back-to-back pops of the same FIFO are legal, because `empty` reflects the decremented count in the following cycle.
- No eligible FIFO or no credit: fifo_pop = 0; pointer holds.
- An index ≥ NUM_FIFO never wins. The pointer wraps from NUM_FIFO-1 to 0.
- Reset, including mid-operation:
  - fifo_pop = 0, out_valid = 0, out_data = 0, out_id = 0.
  - occ = 0, inflight = 0, last_grant = NUM_FIFO-1, burst counter = 0.
  - Words in flight or buffered are discarded. The FIFOs share the same reset.
- fifo_pop depends combinationally on fifo_empty, out_ready and registered state. No other combinational input-to-output path exists.

## Timing
- Pop in cycle t → fifo_data valid in cycle t+1 → captured at the end of t+1 → out_valid in cycle t+2 (latency 2 when the buffer was empty).
- Sustained throughput is 1 word/cycle while out_ready = 1 and any FIFO is non-empty.
- out_ready low for k cycles: at most 2 words are buffered. pop stops when credit reaches 0 and resumes in the same cycle out_ready returns high.
- out_data/out_id are stable while out_valid && !out_ready.

## Configuration
- ARB_BURST_EN defined:
  - A grant holds on the current FIFO while it remains eligible and the burst counter < MAX_BURST.
  - The counter increments per pop.
  - The burst ends when the FIFO goes empty, when MAX_BURST pops are reached, or on reset. The counter then clears and round-robin resumes from the burst FIFO + 1.
  - Cycles with no credit do not end a burst.
- ARB_BURST_EN undefined: strict round-robin with one pop per grant. MAX_BURST is ignored and no burst counter is built.

## Structure
- Shared package `fifo_arb_pkg`:
  - skid-buffer depth constant (2);
  - id typedef sized ID_WIDTH;
  - packed entry typedef {id, data}.
- One sub-module: `rr_pick`, a combinational round-robin priority selector.
  - Inputs: request vector and last_grant.
  - Outputs: one-hot grant and encoded index.
  - Reused by other arbiters.
- Skid buffer and credit logic stay inline.

## Test plan
- Reset, then FIFO 2 only non-empty holding 0xA0, out_ready = 1 → fifo_pop = 4'b0100 in cycle 0; out_valid with out_data = 0xA0, out_id = 2 in cycle 2.
- All four FIFOs hold 3 words, out_ready = 1, burst off → pop order 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles; 12 outputs with ids in the same order and no bubbles.
- Same stimulus with ARB_BURST_EN and MAX_BURST = 2 → ids 0,0,1,1,2,2,3,3,0,1,2,3.
- FIFO 1 holds 5 words; out_ready held low for 6 cycles from cycle 1 → exactly 2 pops, out_data stable; on release the remaining 3 pops follow; all 5 words are delivered in order with none lost.
- Only FIFO 3 non-empty → the pointer wraps: the next grant after FIFO 3 evaluates 0,1,2,3 and picks 3 again with no idle cycle.
- Reset asserted the cycle after a pop with the buffer holding 1 word → next cycle out_valid = 0, fifo_pop = 0, out_data = 0; the in-flight word never appears.
